// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: FSM states,
// parity mode codes and the 3-sample majority voter.
package uart_rx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  function automatic logic vote3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit divider: counts 0..DIV-1 and wraps, with strobes at the three
// mid-bit sample points H-1, H, H+1 (H = DIV/2) and at the last count.
module uart_bit_timer #(
  parameter int unsigned DIV = 286
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic smp_lo_c,
  output logic smp_mid_c,
  output logic smp_hi_c,
  output logic wrap_c
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned H  = DIV / 2;

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_c    = (cnt_q == CW'(DIV - 1));
  assign smp_lo_c  = (cnt_q == CW'(H - 1));
  assign smp_mid_c = (cnt_q == CW'(H));
  assign smp_hi_c  = (cnt_q == CW'(H + 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || wrap_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, 3-sample voter, frame FSM,
// error detection and a one-entry valid/ready holding register.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 33000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned BCW = $clog2(DATA_BITS + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rs_prev_q, rs_prev_d;
  rx_state_e              state_q, state_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   s_lo_q, s_lo_d;
  logic                   s_mid_q, s_mid_d;
  logic                   par_bit_q, par_bit_d;
  logic                   stop1_q, stop1_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   pe_q, pe_d;
  logic                   fe_q, fe_d;
  logic                   ov_q, ov_d;
  logic                   bk_q, bk_d;

  logic rs_c;
  logic vote_c;
  logic restart_c;
  logic done_c;
  logic stop_ok_c;
  logic stop_any_high_c;
  logic smp_lo_c, smp_mid_c, smp_hi_c, wrap_c;

  uart_bit_timer #(
    .DIV(DIV)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart_c),
    .smp_lo_c (smp_lo_c),
    .smp_mid_c(smp_mid_c),
    .smp_hi_c (smp_hi_c),
    .wrap_c   (wrap_c)
  );

  assign rs_c   = sync_q[SYNC_STAGES-1];
  assign vote_c = vote3({s_lo_q, s_mid_q, rs_c});

  assign data       = data_q;
  assign data_valid = valid_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;
  assign break_det  = bk_q;

  // Frame FSM, sampling and shift register
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rx};
    rs_prev_d = rs_c;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    s_lo_d    = s_lo_q;
    s_mid_d   = s_mid_q;
    par_bit_d = par_bit_q;
    stop1_d   = stop1_q;
    restart_c = 1'b0;
    done_c    = 1'b0;

    if (smp_lo_c)  s_lo_d  = rs_c;
    if (smp_mid_c) s_mid_d = rs_c;

    case (state_q)
      ST_IDLE: begin
        // A break leaves rs low here, so no new frame until the line recovers
        if (rs_prev_q && !rs_c) begin
          state_d   = ST_START;
          restart_c = 1'b1;
        end
      end
      ST_START: begin
        if (smp_hi_c && vote_c) begin
          state_d = ST_IDLE;
        end else if (wrap_c) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (smp_hi_c) begin
          shreg_d   = {vote_c, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
        if (wrap_c && (bit_cnt_q == BCW'(DATA_BITS))) begin
          state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP1;
        end
      end
      ST_PARITY: begin
        if (smp_hi_c) par_bit_d = vote_c;
        if (wrap_c)   state_d   = ST_STOP1;
      end
      ST_STOP1: begin
        // Single stop bit ends the frame at mid-bit to allow early resync
        if (smp_hi_c) begin
          stop1_d = vote_c;
          if (STOP_BITS == 1) begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        if (wrap_c) state_d = ST_STOP2;
      end
      ST_STOP2: begin
        if (smp_hi_c) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Completion: holding register, overrun and error pulses
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    bk_d    = 1'b0;

    if (state_q == ST_STOP2) begin
      stop_ok_c       = stop1_q & vote_c;
      stop_any_high_c = stop1_q | vote_c;
    end else begin
      stop_ok_c       = vote_c;
      stop_any_high_c = vote_c;
    end

    if (valid_q && data_ready) valid_d = 1'b0;

    if (done_c) begin
      if (!valid_q || data_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
      pe_d = (PARITY != PARITY_NONE) &&
             ((^shreg_q ^ par_bit_q) != (PARITY == PARITY_ODD));
      fe_d = !stop_ok_c;
      bk_d = (shreg_q == '0) &&
             ((PARITY == PARITY_NONE) || !par_bit_q) &&
             !stop_any_high_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      rs_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      s_lo_q    <= 1'b1;
      s_mid_q   <= 1'b1;
      par_bit_q <= 1'b0;
      stop1_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      bk_q      <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      rs_prev_q <= rs_prev_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      s_lo_q    <= s_lo_d;
      s_mid_q   <= s_mid_d;
      par_bit_q <= par_bit_d;
      stop1_q   <= stop1_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
      bk_q      <= bk_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: default 8N1, even-parity 8E1 and a
// 7N2 instance driven 2% fast, plus reset and error scenarios.
module tb_uart_rx_cfg;

  localparam int DIV0 = 286;
  localparam int H0   = DIV0 / 2;
  localparam int LAT0 = 2 + 9 * DIV0 + H0 + 2;
  localparam int DIV1 = 16;
  localparam int DIV2 = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic v0, v1, v2;
  logic pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, bk0, bk1, bk2;

  int errs = 0;
  int checks = 0;
  int lat_cnt = 0;
  int pe_n[3] = '{0, 0, 0};
  int fe_n[3] = '{0, 0, 0};
  int ov_n[3] = '{0, 0, 0};
  int bk_n[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  uart_rx_cfg u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .data(d0), .data_valid(v0),
    .data_ready(rdy0), .parity_err(pe0), .frame_err(fe0), .overrun(ov0),
    .break_det(bk0)
  );

  uart_rx_cfg #(
    .CLK_HZ(1600000), .BAUD(100000), .PARITY(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .data(d1), .data_valid(v1),
    .data_ready(rdy1), .parity_err(pe1), .frame_err(fe1), .overrun(ov1),
    .break_det(bk1)
  );

  uart_rx_cfg #(
    .CLK_HZ(10000000), .BAUD(100000), .DATA_BITS(7), .STOP_BITS(2)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx2), .data(d2), .data_valid(v2),
    .data_ready(rdy2), .parity_err(pe2), .frame_err(fe2), .overrun(ov2),
    .break_det(bk2)
  );

  // Error pulses are one cycle wide; count them mid-cycle
  always @(negedge clk) begin
    if (pe0 === 1'b1) pe_n[0]++;
    if (pe1 === 1'b1) pe_n[1]++;
    if (pe2 === 1'b1) pe_n[2]++;
    if (fe0 === 1'b1) fe_n[0]++;
    if (fe1 === 1'b1) fe_n[1]++;
    if (fe2 === 1'b1) fe_n[2]++;
    if (ov0 === 1'b1) ov_n[0]++;
    if (ov1 === 1'b1) ov_n[1]++;
    if (ov2 === 1'b1) ov_n[2]++;
    if (bk0 === 1'b1) bk_n[0]++;
    if (bk1 === 1'b1) bk_n[1]++;
    if (bk2 === 1'b1) bk_n[2]++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic pulse_ready(input int inst);
    case (inst)
      0:       rdy0 = 1'b1;
      1:       rdy1 = 1'b1;
      default: rdy2 = 1'b1;
    endcase
    tick(1);
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    rdy2 = 1'b0;
  endtask

  task automatic send_frame(input int inst, input logic [7:0] d, input int nbits,
                            input bit use_par, input logic pbit, input int nstop,
                            input logic sbit, input int per);
    set_rx(inst, 1'b0);
    tick(per);
    for (int i = 0; i < nbits; i++) begin
      set_rx(inst, d[i]);
      tick(per);
    end
    if (use_par) begin
      set_rx(inst, pbit);
      tick(per);
    end
    for (int i = 0; i < nstop; i++) begin
      set_rx(inst, sbit);
      tick(per);
    end
    set_rx(inst, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if (d0 !== 8'h00) begin errs++; $display("FAIL reset_u0_data got=%h exp=00", d0); end
    checks++;
    if (v0 !== 1'b0) begin errs++; $display("FAIL reset_u0_valid got=%b exp=0", v0); end
    checks++;
    if ({pe0, fe0, ov0, bk0} !== 4'b0000)
      begin errs++; $display("FAIL reset_u0_flags got=%b exp=0000", {pe0, fe0, ov0, bk0}); end
    checks++;
    if ({v1, d1} !== 9'h000) begin errs++; $display("FAIL reset_u1 got=%b/%h exp=0/00", v1, d1); end
    checks++;
    if ({v2, d2} !== 8'h00) begin errs++; $display("FAIL reset_u2 got=%b/%h exp=0/00", v2, d2); end
    rst_n = 1'b1;
    tick(20);
    checks++;
    if ({v0, v1, v2} !== 3'b000)
      begin errs++; $display("FAIL post_reset_idle got=%b exp=000", {v0, v1, v2}); end
  endtask

  task automatic test_basic();
    int f0, p0, o0, b0;
    f0 = fe_n[0]; p0 = pe_n[0]; o0 = ov_n[0]; b0 = bk_n[0];
    lat_cnt = 0;
    fork
      send_frame(0, 8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, DIV0);
      begin
        while (v0 !== 1'b1 && lat_cnt < 4000) begin
          tick(1);
          lat_cnt++;
        end
      end
    join
    checks++;
    if (lat_cnt < LAT0 - 1 || lat_cnt > LAT0 + 1)
      begin errs++; $display("FAIL basic_latency got=%0d exp=%0d+-1", lat_cnt, LAT0); end
    checks++;
    if (d0 !== 8'hA5) begin errs++; $display("FAIL basic_data got=%h exp=a5", d0); end
    checks++;
    if (v0 !== 1'b1) begin errs++; $display("FAIL basic_valid got=%b exp=1", v0); end
    checks++;
    if ((fe_n[0] - f0) + (pe_n[0] - p0) + (ov_n[0] - o0) + (bk_n[0] - b0) != 0)
      begin errs++; $display("FAIL basic_no_flags got=%0d pulses exp=0",
        (fe_n[0] - f0) + (pe_n[0] - p0) + (ov_n[0] - o0) + (bk_n[0] - b0)); end
    pulse_ready(0);
    checks++;
    if (v0 !== 1'b0) begin errs++; $display("FAIL basic_consume got=%b exp=0", v0); end
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ov_n[0];
    send_frame(0, 8'h11, 8, 1'b0, 1'b0, 1, 1'b1, DIV0);
    tick(10);
    checks++;
    if ({v0, d0} !== {1'b1, 8'h11}) begin errs++; $display("FAIL ovr_first got=%b/%h exp=1/11", v0, d0); end
    send_frame(0, 8'h22, 8, 1'b0, 1'b0, 1, 1'b1, DIV0);
    tick(10);
    checks++;
    if (d0 !== 8'h11) begin errs++; $display("FAIL ovr_held_data got=%h exp=11", d0); end
    checks++;
    if (v0 !== 1'b1) begin errs++; $display("FAIL ovr_valid got=%b exp=1", v0); end
    checks++;
    if (ov_n[0] - o0 != 1) begin errs++; $display("FAIL ovr_pulses got=%0d exp=1", ov_n[0] - o0); end
    pulse_ready(0);
    checks++;
    if (v0 !== 1'b0) begin errs++; $display("FAIL ovr_consume got=%b exp=0", v0); end
  endtask

  task automatic test_glitch();
    int f0, p0, o0, b0;
    f0 = fe_n[0]; p0 = pe_n[0]; o0 = ov_n[0]; b0 = bk_n[0];
    set_rx(0, 1'b0);
    tick(DIV0 / 4);
    set_rx(0, 1'b1);
    tick(3 * DIV0);
    checks++;
    if (v0 !== 1'b0) begin errs++; $display("FAIL glitch_valid got=%b exp=0", v0); end
    checks++;
    if ((fe_n[0] - f0) + (pe_n[0] - p0) + (ov_n[0] - o0) + (bk_n[0] - b0) != 0)
      begin errs++; $display("FAIL glitch_flags got=%0d pulses exp=0",
        (fe_n[0] - f0) + (pe_n[0] - p0) + (ov_n[0] - o0) + (bk_n[0] - b0)); end
    send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, DIV0);
    tick(10);
    checks++;
    if ({v0, d0} !== {1'b1, 8'h3C}) begin errs++; $display("FAIL glitch_next got=%b/%h exp=1/3c", v0, d0); end
    pulse_ready(0);
  endtask

  task automatic test_parity();
    int p1, f1;
    p1 = pe_n[1]; f1 = fe_n[1];
    send_frame(1, 8'h07, 8, 1'b1, 1'b1, 1, 1'b1, DIV1);
    tick(4);
    checks++;
    if ({v1, d1} !== {1'b1, 8'h07}) begin errs++; $display("FAIL par_good_data got=%b/%h exp=1/07", v1, d1); end
    checks++;
    if (pe_n[1] - p1 != 0) begin errs++; $display("FAIL par_good_err got=%0d exp=0", pe_n[1] - p1); end
    pulse_ready(1);
    send_frame(1, 8'h07, 8, 1'b1, 1'b0, 1, 1'b1, DIV1);
    tick(4);
    checks++;
    if (pe_n[1] - p1 != 1) begin errs++; $display("FAIL par_bad_err got=%0d exp=1", pe_n[1] - p1); end
    checks++;
    if ({v1, d1} !== {1'b1, 8'h07}) begin errs++; $display("FAIL par_bad_data got=%b/%h exp=1/07", v1, d1); end
    checks++;
    if (fe_n[1] - f1 != 0) begin errs++; $display("FAIL par_frame got=%0d exp=0", fe_n[1] - f1); end
  endtask

  task automatic test_frame_err();
    int f0, b0;
    f0 = fe_n[0]; b0 = bk_n[0];
    send_frame(0, 8'h55, 8, 1'b0, 1'b0, 1, 1'b0, DIV0);
    tick(10);
    checks++;
    if (fe_n[0] - f0 != 1) begin errs++; $display("FAIL ferr_pulse got=%0d exp=1", fe_n[0] - f0); end
    checks++;
    if (bk_n[0] - b0 != 0) begin errs++; $display("FAIL ferr_break got=%0d exp=0", bk_n[0] - b0); end
    checks++;
    if ({v0, d0} !== {1'b1, 8'h55}) begin errs++; $display("FAIL ferr_data got=%b/%h exp=1/55", v0, d0); end
    pulse_ready(0);
  endtask

  task automatic test_break();
    int f0, b0, o0;
    f0 = fe_n[0]; b0 = bk_n[0]; o0 = ov_n[0];
    set_rx(0, 1'b0);
    tick(30 * DIV0);
    checks++;
    if (bk_n[0] - b0 != 1) begin errs++; $display("FAIL brk_pulse got=%0d exp=1", bk_n[0] - b0); end
    checks++;
    if (fe_n[0] - f0 != 1) begin errs++; $display("FAIL brk_frame got=%0d exp=1", fe_n[0] - f0); end
    checks++;
    if (ov_n[0] - o0 != 0) begin errs++; $display("FAIL brk_overrun got=%0d exp=0", ov_n[0] - o0); end
    checks++;
    if ({v0, d0} !== {1'b1, 8'h00}) begin errs++; $display("FAIL brk_data got=%b/%h exp=1/00", v0, d0); end
    set_rx(0, 1'b1);
    tick(2 * DIV0);
    checks++;
    if (bk_n[0] - b0 != 1) begin errs++; $display("FAIL brk_after_high got=%0d exp=1", bk_n[0] - b0); end
    pulse_ready(0);
    send_frame(0, 8'hC3, 8, 1'b0, 1'b0, 1, 1'b1, DIV0);
    tick(10);
    checks++;
    if ({v0, d0} !== {1'b1, 8'hC3}) begin errs++; $display("FAIL brk_rearm got=%b/%h exp=1/c3", v0, d0); end
    pulse_ready(0);
  endtask

  task automatic test_7n2_fast();
    int f2, p2, b2;
    f2 = fe_n[2]; p2 = pe_n[2]; b2 = bk_n[2];
    send_frame(2, 8'h41, 7, 1'b0, 1'b0, 2, 1'b1, DIV2 - 2);
    tick(10);
    checks++;
    if ({v2, d2} !== {1'b1, 7'h41}) begin errs++; $display("FAIL 7n2_data got=%b/%h exp=1/41", v2, d2); end
    checks++;
    if ((fe_n[2] - f2) + (pe_n[2] - p2) + (bk_n[2] - b2) != 0)
      begin errs++; $display("FAIL 7n2_flags got=%0d exp=0", (fe_n[2] - f2) + (pe_n[2] - p2) + (bk_n[2] - b2)); end
    pulse_ready(2);
    checks++;
    if (v2 !== 1'b0) begin errs++; $display("FAIL 7n2_consume got=%b exp=0", v2); end
  endtask

  task automatic test_reset_mid();
    int f2;
    // u1 still holds the word from the bad-parity frame
    set_rx(2, 1'b0); tick(DIV2);
    set_rx(2, 1'b1); tick(DIV2);
    set_rx(2, 1'b0); tick(DIV2 + DIV2 / 2);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({v1, d1} !== 9'h000) begin errs++; $display("FAIL rstmid_u1 got=%b/%h exp=0/00", v1, d1); end
    checks++;
    if ({v2, d2} !== 8'h00) begin errs++; $display("FAIL rstmid_u2 got=%b/%h exp=0/00", v2, d2); end
    checks++;
    if ({pe2, fe2, ov2, bk2} !== 4'b0000)
      begin errs++; $display("FAIL rstmid_flags got=%b exp=0000", {pe2, fe2, ov2, bk2}); end
    set_rx(2, 1'b1);
    tick(5);
    rst_n = 1'b1;
    tick(3 * DIV2);
    checks++;
    if (v2 !== 1'b0) begin errs++; $display("FAIL rstmid_idle got=%b exp=0", v2); end
    f2 = fe_n[2];
    send_frame(2, 8'h41, 7, 1'b0, 1'b0, 2, 1'b1, DIV2);
    tick(10);
    checks++;
    if ({v2, d2} !== {1'b1, 7'h41}) begin errs++; $display("FAIL rstmid_next got=%b/%h exp=1/41", v2, d2); end
    checks++;
    if (fe_n[2] - f2 != 0) begin errs++; $display("FAIL rstmid_frame got=%0d exp=0", fe_n[2] - f2); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_overrun();
    test_glitch();
    test_parity();
    test_frame_err();
    test_break();
    test_7n2_fast();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
